// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and default widths for the pipeline run controller.
// The UI handler decodes the exported state with these same enum values.
package pipe_ctrl_pkg;

  localparam int PC_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } run_state_e;

endpackage

// File: rtl/pipe_run_ctrl.sv
// Run/step/breakpoint sequencer producing a single-cycle pipeline advance enable.
//   state  | meaning
//   IDLE   | halted, waiting for run_mode or a step pulse
//   RUN    | free-running, one advance per tick until halt/breakpoint
//   STEP   | one-cycle state that schedules exactly one advance
//   BREAK  | stopped on a fetch-PC breakpoint, waiting for step or exit
module pipe_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             step,
  input  logic             run_mode,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             advance,
  output logic             running,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] step_count
);

  run_state_e       state_q, state_d;
  logic             advance_q, advance_d;
  logic             skip_q, skip_d;
  logic             running_q, running_d;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic             bp_match;

  assign bp_match = bp_en && (pc == bp_addr) && !skip_q;

  always_comb begin
    state_d      = state_q;
    advance_d    = 1'b0;
    skip_d       = skip_q;
    step_count_d = step_count_q + {{(CNT_W-1){1'b0}}, advance_q};
    unique case (state_q)
      ST_IDLE: begin
        if (halt_req)      state_d = ST_IDLE;
        else if (run_mode) state_d = ST_RUN;
        else if (step)     state_d = ST_STEP;
      end
      ST_RUN: begin
        if (halt_req || !run_mode) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (bp_match) begin
            state_d = ST_BREAK;
          end else begin
            advance_d = 1'b1;
            skip_d    = 1'b0;
          end
        end
      end
      ST_STEP: begin
        advance_d = 1'b1;
        state_d   = (run_mode && !halt_req) ? ST_RUN : ST_IDLE;
      end
      ST_BREAK: begin
        if (halt_req || !run_mode) begin
          state_d = ST_IDLE;
        end else if (step) begin
          // Let the stepped instruction leave the breakpoint PC without re-trapping.
          state_d = ST_STEP;
          skip_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);
    bp_hit_d  = (state_d == ST_BREAK);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      advance_q    <= 1'b0;
      skip_q       <= 1'b0;
      running_q    <= 1'b0;
      bp_hit_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      advance_q    <= advance_d;
      skip_q       <= skip_d;
      running_q    <= running_d;
      bp_hit_q     <= bp_hit_d;
      step_count_q <= step_count_d;
    end
  end

  assign advance    = advance_q;
  assign running    = running_q;
  assign state      = state_q;
  assign bp_hit     = bp_hit_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl: reset, manual step, auto-run, breakpoint,
// halt priority, counter wrap and asynchronous reset mid-run.
module tb_pipe_run_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        tick, step, run_mode, halt_req, bp_en;
  logic [15:0] bp_addr, pc;
  logic        advance, running, bp_hit;
  logic [1:0]  state;
  logic [15:0] step_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  pipe_run_ctrl dut (
    .clock(clock), .reset(reset), .tick(tick), .step(step),
    .run_mode(run_mode), .halt_req(halt_req), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .advance(advance), .running(running),
    .state(state), .bp_hit(bp_hit), .step_count(step_count)
  );

  always #5 clock = ~clock;

  // Advance one clock, land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 0; step = 0; run_mode = 0; halt_req = 0;
    bp_en = 0; bp_addr = 16'h0; pc = 16'h0;
    cyc(); cyc();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", state); end
    checks++; if (advance !== 1'b0 || running !== 1'b0 || bp_hit !== 1'b0) begin
      errors++; $display("FAIL reset_outs adv=%b run=%b bp=%b exp=0", advance, running, bp_hit); end
    checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", step_count); end
    reset = 1'b0;
    cyc(); cyc();
    checks++; if (state !== 2'b00 || advance !== 1'b0) begin
      errors++; $display("FAIL reset_idle state=%b adv=%b exp=00/0", state, advance); end
  endtask

  task automatic test_manual_step();
    int adv_seen = 0;
    run_mode = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1; cyc(); step = 1'b0;
      checks++; if (state !== 2'b10 || advance !== 1'b0) begin
        errors++; $display("FAIL step_state p=%0d state=%b adv=%b exp=10/0", p, state, advance); end
      cyc();
      checks++; if (advance !== 1'b1 || state !== 2'b00) begin
        errors++; $display("FAIL step_adv p=%0d adv=%b state=%b exp=1/00", p, advance, state); end
      if (advance === 1'b1) adv_seen++;
      for (int k = 0; k < 3; k++) begin
        cyc();
        if (advance === 1'b1) adv_seen++;
      end
    end
    exp_cnt += 3;
    checks++; if (adv_seen != 3) begin errors++; $display("FAIL step_pulses got=%0d exp=3", adv_seen); end
    checks++; if (step_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL step_cnt got=%0d exp=%0d", step_count, exp_cnt); end
  endtask

  task automatic test_auto_run();
    int adv_ok = 0;
    int run_bad = 0;
    bp_en = 0; run_mode = 1;
    cyc();
    checks++; if (state !== 2'b01 || running !== 1'b1) begin
      errors++; $display("FAIL run_enter state=%b running=%b exp=01/1", state, running); end
    for (int t = 0; t < 10; t++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      if (advance === 1'b1) adv_ok++;
      if (running !== 1'b1) run_bad++;
      for (int k = 0; k < 3; k++) begin
        cyc();
        if (advance !== 1'b0) adv_ok += 100;
        if (running !== 1'b1) run_bad++;
      end
    end
    exp_cnt += 10;
    checks++; if (adv_ok != 10) begin errors++; $display("FAIL run_advances got=%0d exp=10", adv_ok); end
    checks++; if (run_bad != 0) begin errors++; $display("FAIL run_running low_cycles=%0d exp=0", run_bad); end
    checks++; if (step_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL run_cnt got=%0d exp=%0d", step_count, exp_cnt); end
  endtask

  task automatic test_breakpoint();
    bp_en = 1; bp_addr = 16'h0010; pc = 16'h000F;
    tick = 1; cyc(); tick = 0;
    checks++; if (advance !== 1'b1 || state !== 2'b01) begin
      errors++; $display("FAIL bp_pre adv=%b state=%b exp=1/01", advance, state); end
    pc = 16'h0010; cyc();
    tick = 1; cyc(); tick = 0;
    checks++; if (state !== 2'b11 || bp_hit !== 1'b1 || advance !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL bp_hit state=%b bp=%b adv=%b run=%b exp=11/1/0/0", state, bp_hit, advance, running); end
    tick = 1; cyc(); tick = 0;
    checks++; if (state !== 2'b11 || advance !== 1'b0) begin
      errors++; $display("FAIL bp_tick_ignored state=%b adv=%b exp=11/0", state, advance); end
    step = 1; cyc(); step = 0;
    checks++; if (state !== 2'b10 || bp_hit !== 1'b0) begin
      errors++; $display("FAIL bp_step state=%b bp=%b exp=10/0", state, bp_hit); end
    cyc();
    checks++; if (advance !== 1'b1 || state !== 2'b01) begin
      errors++; $display("FAIL bp_step_adv adv=%b state=%b exp=1/01", advance, state); end
    // PC still at the breakpoint: skip flag must suppress the re-trap once.
    cyc();
    tick = 1; cyc(); tick = 0;
    checks++; if (advance !== 1'b1 || state !== 2'b01) begin
      errors++; $display("FAIL bp_skip adv=%b state=%b exp=1/01", advance, state); end
    pc = 16'h0011; cyc();
    tick = 1; cyc(); tick = 0;
    checks++; if (advance !== 1'b1 || state !== 2'b01) begin
      errors++; $display("FAIL bp_next adv=%b state=%b exp=1/01", advance, state); end
    pc = 16'h0010; cyc();
    tick = 1; cyc(); tick = 0;
    checks++; if (state !== 2'b11 || advance !== 1'b0) begin
      errors++; $display("FAIL bp_rearm state=%b adv=%b exp=11/0", state, advance); end
    exp_cnt += 4;
    run_mode = 0; cyc();
    checks++; if (state !== 2'b00 || bp_hit !== 1'b0) begin
      errors++; $display("FAIL bp_exit state=%b bp=%b exp=00/0", state, bp_hit); end
    checks++; if (step_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL bp_cnt got=%0d exp=%0d", step_count, exp_cnt); end
    bp_en = 0; pc = 16'h0;
  endtask

  task automatic test_halt_priority();
    run_mode = 1; cyc();
    halt_req = 1; tick = 1; cyc(); tick = 0;
    checks++; if (state !== 2'b00 || advance !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL halt_tick state=%b adv=%b run=%b exp=00/0/0", state, advance, running); end
    step = 1; cyc(); step = 0;
    checks++; if (state !== 2'b00 || advance !== 1'b0) begin
      errors++; $display("FAIL halt_hold state=%b adv=%b exp=00/0", state, advance); end
    halt_req = 0; run_mode = 0; cyc();
  endtask

  task automatic test_wrap();
    int n;
    n = 65535 - exp_cnt;
    run_mode = 1; cyc();
    tick = 1;
    for (int i = 0; i < n; i++) cyc();
    tick = 0;
    cyc(); cyc();
    checks++; if (step_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_pre got=%h exp=ffff", step_count); end
    tick = 1; cyc(); tick = 0;
    cyc();
    checks++; if (step_count !== 16'h0000) begin
      errors++; $display("FAIL wrap got=%h exp=0000", step_count); end
    exp_cnt = 0;
  endtask

  task automatic test_reset_mid_run();
    tick = 1; cyc();
    checks++; if (advance !== 1'b1 || state !== 2'b01) begin
      errors++; $display("FAIL rst_pre adv=%b state=%b exp=1/01", advance, state); end
    #2 reset = 1'b1;
    #1;
    checks++; if (state !== 2'b00 || advance !== 1'b0 || step_count !== 16'd0 || running !== 1'b0) begin
      errors++; $display("FAIL rst_async state=%b adv=%b cnt=%0d run=%b exp=00/0/0/0", state, advance, step_count, running); end
    tick = 0; run_mode = 0;
    cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    checks++; if (state !== 2'b00 || advance !== 1'b0 || step_count !== 16'd0) begin
      errors++; $display("FAIL rst_after state=%b adv=%b cnt=%0d exp=00/0/0", state, advance, step_count); end
  endtask

  initial begin
    test_reset();
    test_manual_step();
    test_auto_run();
    test_breakpoint();
    test_halt_priority();
    test_wrap();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
